// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the i2c master arbiter
//
// Purpose: state encoding, status codes and field widths used by
//          i2c_master_arbiter and i2c_rr_arbiter.
// Ports:   none (package).
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } arb_state_e;

    localparam logic [3:0] STATUS_OK       = 4'h0;
    localparam logic [3:0] STATUS_NO_START = 4'hF;

    localparam int ADDR_W = 7;
    localparam int REG_W  = 8;
    localparam int DATA_W = 16;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// rtl/i2c_rr_arbiter.sv - combinational round-robin pick
//
// Purpose: picks the first requester after `last` (upward, wrapping).
// Ports:   req   - request levels, one bit per requester
//          last  - id of the previous owner
//          valid - at least one request is pending
//          id    - winning requester (equals last when valid is low)
module i2c_rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last,
    output logic               valid,
    output logic [IDW-1:0]     id
);

    int             idx;
    logic [IDW-1:0] sel;

    // Walk candidates from farthest (last itself) to nearest (last+1);
    // the nearest pending one is written last and therefore wins.
    always_comb begin
        valid = 1'b0;
        id    = last;
        idx   = 0;
        sel   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            sel = idx[IDW-1:0];
            if (req[sel]) begin
                valid = 1'b1;
                id    = sel;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin sharing of one i2c_master between requesters
//
// Purpose: grants one requester at a time, forwards its chip/register address,
//          write data and direction to the master, pulses read_en/write_en,
//          follows master busy to completion and returns data/status with a
//          one-cycle one-hot ack. Optional re-launch on error status is enabled
//          by defining I2C_ARB_RETRY_EN.
// Ports:   clk, reset (async, active-high)
//          req/req_rnw/req_chip_addr/req_reg_addr/req_wdata - packed requester side
//          ack, rsp_data, rsp_status, grant_id             - response side
//          m_chip_addr/m_reg_addr/m_data_in/m_write_en/m_read_en - to master
//          m_busy/m_status/m_data_out                           - from master
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LAUNCH_WAIT = 8,
    parameter int MAX_RETRY   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_rnw,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_chip_addr,
    input  logic [NUM_REQ*REG_W-1:0]    req_reg_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [3:0]                  rsp_status,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic [ADDR_W-1:0]           m_chip_addr,
    output logic [REG_W-1:0]            m_reg_addr,
    output logic [DATA_W-1:0]           m_data_in,
    output logic                        m_write_en,
    output logic                        m_read_en,
    input  logic                        m_busy,
    input  logic [3:0]                  m_status,
    input  logic [DATA_W-1:0]           m_data_out
);

    localparam int IDW = $clog2(NUM_REQ);
    // One width covers both the start-timeout counter and the retry counter.
    localparam int CNT_W = $clog2(((LAUNCH_WAIT > MAX_RETRY) ? LAUNCH_WAIT : MAX_RETRY) + 1);

    arb_state_e          state_q;
    logic [IDW-1:0]      grant_q;
    logic [IDW-1:0]      last_q;
    logic                rnw_q;
    logic [CNT_W-1:0]    cnt_q;
`ifdef I2C_ARB_RETRY_EN
    logic [CNT_W-1:0]    retry_q;
`endif
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [3:0]          rsp_status_q;
    logic [ADDR_W-1:0]   chip_q;
    logic [REG_W-1:0]    reg_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                write_en_q;
    logic                read_en_q;

    logic                rr_valid;
    logic [IDW-1:0]      rr_id;
    logic [ADDR_W-1:0]   win_chip_d;
    logic [REG_W-1:0]    win_reg_d;
    logic [DATA_W-1:0]   win_wdata_d;
    logic                win_rnw_d;

    i2c_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req),
        .last  (last_q),
        .valid (rr_valid),
        .id    (rr_id)
    );

    // Unpack the winner's transaction fields.
    always_comb begin
        win_chip_d  = '0;
        win_reg_d   = '0;
        win_wdata_d = '0;
        win_rnw_d   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_id == IDW'(i)) begin
                win_chip_d  = req_chip_addr[i*ADDR_W +: ADDR_W];
                win_reg_d   = req_reg_addr[i*REG_W +: REG_W];
                win_wdata_d = req_wdata[i*DATA_W +: DATA_W];
                win_rnw_d   = req_rnw[i];
            end
        end
    end

    // Launch pulses and ack are set on the transition into LAUNCH / RESP,
    // so they are high exactly while the FSM sits in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_q       <= IDW'(NUM_REQ - 1);
            rnw_q        <= 1'b0;
            cnt_q        <= '0;
`ifdef I2C_ARB_RETRY_EN
            retry_q      <= '0;
`endif
            ack_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            chip_q       <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            ack_q      <= '0;
            case (state_q)
                ST_IDLE: begin
                    // Master may still be busy from before an arbiter reset.
                    if (rr_valid && !m_busy) begin
                        grant_q    <= rr_id;
                        chip_q     <= win_chip_d;
                        reg_q      <= win_reg_d;
                        wdata_q    <= win_wdata_d;
                        rnw_q      <= win_rnw_d;
                        read_en_q  <= win_rnw_d;
                        write_en_q <= !win_rnw_d;
`ifdef I2C_ARB_RETRY_EN
                        retry_q    <= '0;
`endif
                        state_q    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (m_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == CNT_W'(LAUNCH_WAIT - 1)) begin
                        rsp_status_q   <= STATUS_NO_START;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!m_busy) begin
`ifdef I2C_ARB_RETRY_EN
                        if (m_status != STATUS_OK && m_status != STATUS_NO_START &&
                            retry_q < CNT_W'(MAX_RETRY)) begin
                            retry_q    <= retry_q + 1'b1;
                            read_en_q  <= rnw_q;
                            write_en_q <= !rnw_q;
                            state_q    <= ST_LAUNCH;
                        end else
`endif
                        begin
                            // Writes leave rsp_data at the last read value.
                            if (rnw_q) begin
                                rsp_data_q <= m_data_out;
                            end
                            rsp_status_q   <= m_status;
                            ack_q[grant_q] <= 1'b1;
                            state_q        <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    last_q  <= grant_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack         = ack_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign grant_id    = grant_q;
    assign m_chip_addr = chip_q;
    assign m_reg_addr  = reg_q;
    assign m_data_in   = wdata_q;
    assign m_write_en  = write_en_q;
    assign m_read_en   = read_en_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - self-checking bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int MR = 2;
`ifdef I2C_ARB_RETRY_EN
    localparam int NL_MISS = 1 + MR;
`else
    localparam int NL_MISS = 1;
`endif
    localparam logic [6:0] SLAVE = 7'h0F;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_rnw = '0;
    logic [N*7-1:0]  req_chip_addr = '0;
    logic [N*8-1:0]  req_reg_addr = '0;
    logic [N*16-1:0] req_wdata = '0;
    logic [N-1:0]    ack;
    logic [15:0]     rsp_data;
    logic [3:0]      rsp_status;
    logic [1:0]      grant_id;
    logic [6:0]      m_chip_addr;
    logic [7:0]      m_reg_addr;
    logic [15:0]     m_data_in;
    logic            m_write_en;
    logic            m_read_en;
    logic            m_busy = 1'b0;
    logic [3:0]      m_status = 4'h0;
    logic [15:0]     m_data_out = 16'h0;

    int checks = 0;
    int errors = 0;

    i2c_master_arbiter #(.NUM_REQ(N), .LAUNCH_WAIT(LW), .MAX_RETRY(MR)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_rnw       (req_rnw),
        .req_chip_addr (req_chip_addr),
        .req_reg_addr  (req_reg_addr),
        .req_wdata     (req_wdata),
        .ack           (ack),
        .rsp_data      (rsp_data),
        .rsp_status    (rsp_status),
        .grant_id      (grant_id),
        .m_chip_addr   (m_chip_addr),
        .m_reg_addr    (m_reg_addr),
        .m_data_in     (m_data_in),
        .m_write_en    (m_write_en),
        .m_read_en     (m_read_en),
        .m_busy        (m_busy),
        .m_status      (m_status),
        .m_data_out    (m_data_out)
    );

    always #5 clk = ~clk;

    // ---------------- simple i2c master + single slave model ----------------
    logic        dead = 1'b0;
    int          bus_len = 4;
    int          busy_left = 0;
    int          launches = 0;
    logic [6:0]  lat_chip = '0;
    logic [7:0]  lat_reg = '0;
    logic [15:0] lat_data = '0;
    logic        lat_rnw = 1'b0;
    logic [15:0] mem [256];
    bit          wr [256];

    function automatic logic [15:0] dflt(input logic [7:0] r);
        return (r == 8'h0A) ? 16'hB2B2 : {8'h10, r};
    endfunction

    always @(posedge clk) begin
        if (m_read_en || m_write_en) launches <= launches + 1;
        if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                m_busy <= 1'b0;
                if (lat_chip == SLAVE) begin
                    m_status <= 4'h0;
                    if (lat_rnw) m_data_out <= wr[lat_reg] ? mem[lat_reg] : dflt(lat_reg);
                    else begin
                        mem[lat_reg] <= lat_data;
                        wr[lat_reg]  <= 1'b1;
                    end
                end else begin
                    m_status <= 4'h1;
                end
            end
        end else if ((m_read_en || m_write_en) && !dead) begin
            lat_chip  <= m_chip_addr;
            lat_reg   <= m_reg_addr;
            lat_data  <= m_data_in;
            lat_rnw   <= m_read_en;
            m_busy    <= 1'b1;
            busy_left <= bus_len;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic rnw, input logic [6:0] chip,
                           input logic [7:0] ra, input logic [15:0] wd);
        req_rnw[id]              = rnw;
        req_chip_addr[id*7 +: 7]  = chip;
        req_reg_addr[id*8 +: 8]   = ra;
        req_wdata[id*16 +: 16]    = wd;
        req[id]                  = 1'b1;
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ack != '0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          id;
        logic        rnw;
        logic [6:0]  chip;
        logic [7:0]  ra;
        logic [15:0] wd;
        logic [3:0]  est;
        logic [15:0] ed;
        int          nl;
    } vec_t;

    task automatic run_txn(input vec_t v);
        bit got;
        int l0;
        @(negedge clk);
        l0 = launches;
        set_req(v.id, v.rnw, v.chip, v.ra, v.wd);
        wait_ack(got);
        chk("txn_ack_seen", 32'(got), 32'd1);
        chk("txn_ack", 32'(ack), 32'd1 << v.id);
        chk("txn_grant_id", 32'(grant_id), 32'(v.id));
        chk("txn_status", 32'(rsp_status), 32'(v.est));
        if (v.rnw && v.est == 4'h0) chk("txn_rdata", 32'(rsp_data), 32'(v.ed));
        chk("txn_m_chip", 32'(lat_chip), 32'(v.chip));
        chk("txn_m_reg", 32'(lat_reg), 32'(v.ra));
        chk("txn_m_rnw", 32'(lat_rnw), 32'(v.rnw));
        if (!v.rnw) chk("txn_m_wdata", 32'(lat_data), 32'(v.wd));
        chk("txn_launches", 32'(launches - l0), 32'(v.nl));
        req[v.id] = 1'b0;
        @(negedge clk);
        chk("txn_ack_one_cycle", 32'(ack), 32'd0);
    endtask

    vec_t vt [7];

    // ---------------- main sequence ----------------
    initial begin
        bit          got;
        int          n, l0, en_cnt, ack_cnt;
        int          order [5];
        logic [7:0]  ra;

        vt[0] = '{1, 1'b0, SLAVE, 8'h10, 16'h1234, 4'h0, 16'h0000, 1};
        vt[1] = '{1, 1'b1, SLAVE, 8'h10, 16'h0000, 4'h0, 16'h1234, 1};
        vt[2] = '{2, 1'b1, SLAVE, 8'h0A, 16'h0000, 4'h0, 16'hB2B2, 1};
        vt[3] = '{3, 1'b0, SLAVE, 8'h05, 16'hA5A5, 4'h0, 16'h0000, 1};
        vt[4] = '{0, 1'b1, SLAVE, 8'h05, 16'h0000, 4'h0, 16'hA5A5, 1};
        vt[5] = '{1, 1'b1, 7'h22, 8'h00, 16'h0000, 4'h1, 16'h0000, NL_MISS};
        vt[6] = '{0, 1'b0, 7'h22, 8'h07, 16'h5A5A, 4'h1, 16'h0000, NL_MISS};
        order = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_en", 32'({m_write_en, m_read_en}), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_m_addr", 32'({m_chip_addr, m_reg_addr}), 32'd0);
        chk("rst_m_data", 32'(m_data_in), 32'd0);
        chk("rst_rsp", 32'({rsp_data, rsp_status}), 32'd0);
        reset = 1'b0;

        // Contention: all four at once, requester 0 comes back after its ack
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 1'b1, SLAVE, 8'h20 + 8'(i), 16'h0);
        for (int k = 0; k < 5; k++) begin
            wait_ack(got);
            chk("cont_ack_seen", 32'(got), 32'd1);
            chk("cont_ack", 32'(ack), 32'd1 << order[k]);
            chk("cont_grant", 32'(grant_id), 32'(order[k]));
            ra = 8'h20 + 8'(order[k]);
            chk("cont_rdata", 32'(rsp_data), 32'({8'h10, ra}));
            req = req & ~ack;
            if (k == 0) begin
                @(negedge clk);
                req[0] = 1'b1;
            end
        end
        req = '0;

        // Directed single-requester transactions
        for (int i = 0; i < 7; i++) run_txn(vt[i]);

        // No start: master never raises busy
        dead = 1'b1;
        @(negedge clk);
        l0 = launches;
        set_req(3, 1'b0, SLAVE, 8'h30, 16'hBEEF);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_read_en || m_write_en) begin
                got = 1'b1;
                break;
            end
        end
        chk("nostart_launch_seen", 32'(got), 32'd1);
        n = 0;
        while (ack == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("nostart_latency", 32'(n), 32'(LW + 1));
        chk("nostart_ack", 32'(ack), 32'b1000);
        chk("nostart_status", 32'(rsp_status), 32'hF);
        req[3] = 1'b0;
        @(negedge clk);
        chk("nostart_launches", 32'(launches - l0), 32'd1);
        dead = 1'b0;

        // Reset during WAIT_DONE; master stays busy across the reset
        bus_len = 20;
        @(negedge clk);
        set_req(0, 1'b1, SLAVE, 8'h0A, 16'h0);
        n = 0;
        while (!m_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_busy_seen", 32'(m_busy), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_ack", 32'(ack), 32'd0);
        chk("rstmid_grant", 32'(grant_id), 32'd0);
        chk("rstmid_m_addr", 32'({m_chip_addr, m_reg_addr}), 32'd0);
        chk("rstmid_rsp", 32'({rsp_data, rsp_status}), 32'd0);
        reset = 1'b0;
        en_cnt = 0;
        ack_cnt = 0;
        n = 0;
        while (m_busy && n < 100) begin
            @(negedge clk);
            if (m_read_en || m_write_en) en_cnt++;
            if (ack != '0) ack_cnt++;
            n++;
        end
        chk("rstmid_busy_fell", 32'(m_busy), 32'd0);
        chk("rstmid_no_launch_while_busy", 32'(en_cnt), 32'd0);
        chk("rstmid_no_ack", 32'(ack_cnt), 32'd0);
        bus_len = 4;
        wait_ack(got);
        chk("rstmid_relaunch_ack_seen", 32'(got), 32'd1);
        chk("rstmid_relaunch_ack", 32'(ack), 32'd1);
        chk("rstmid_relaunch_data", 32'(rsp_data), 32'hB2B2);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
